// File: rtl/aemb_wbarb_pkg.sv
// Shared encodings and arbitration helper for the two-master Wishbone arbiter.
package aemb_wbarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_D = 2'd1,
        ST_GNT_I = 2'd2
    } state_e;

    localparam logic [1:0] GNT_D = 2'b01;
    localparam logic [1:0] GNT_I = 2'b10;

    localparam logic LAST_D = 1'b0;
    localparam logic LAST_I = 1'b1;

    localparam int TMO_DEFAULT = 255;

    // Round-robin pick: on a tie the master that did not win last time gets the bus.
    function automatic state_e arbitrate(input logic req_d, input logic req_i, input logic last);
        if (req_d && req_i)
            return (last == LAST_I) ? ST_GNT_D : ST_GNT_I;
        else if (req_d)
            return ST_GNT_D;
        else if (req_i)
            return ST_GNT_I;
        else
            return ST_IDLE;
    endfunction

endpackage

// File: rtl/aemb_wbarb_wdt.sv
// Bus watchdog: counts stalled strobe cycles and fires a one-cycle forced ack at TMO.
module aemb_wbarb_wdt #(
    parameter int TMO = 255
) (
    input  logic gclk,
    input  logic grst,
    input  logic stall_i,
    input  logic clr_i,
    output logic fire_o,
    output logic tmo_o
);

    localparam logic [7:0] LIMIT = 8'(TMO);

    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;

    always_comb begin
        fire_o = stall_i && (cnt_q == LIMIT - 8'd1);
        cnt_d  = cnt_q;
        if (clr_i || fire_o)
            cnt_d = 8'd0;
        else if (stall_i)
            cnt_d = cnt_q + 8'd1;
        tmo_d = tmo_q | fire_o;
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            cnt_q <= 8'd0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    // Flag is visible in the same cycle as the forced ack, then held.
    assign tmo_o = tmo_q | fire_o;

endmodule

// File: rtl/aemb_wbarb.sv
// Two-master (data / instruction) Wishbone arbiter with round-robin and bus lock.
// Optional watchdog enabled by defining AEMB_WBARB_WDT_EN.
module aemb_wbarb
    import aemb_wbarb_pkg::*;
#(
    parameter int AW  = 32,
    parameter int TMO = TMO_DEFAULT
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic [AW-1:2] d_adr_i,
    input  logic [3:0]    d_sel_i,
    input  logic [31:0]   d_dat_i,
    input  logic          d_stb_i,
    input  logic          d_cyc_i,
    input  logic          d_wre_i,
    input  logic          d_tag_i,
    output logic [31:0]   d_dat_o,
    output logic          d_ack_o,
    input  logic [AW-1:2] i_adr_i,
    input  logic          i_stb_i,
    input  logic          i_cyc_i,
    input  logic          i_tag_i,
    output logic [31:0]   i_dat_o,
    output logic          i_ack_o,
    output logic [AW-1:2] wb_adr_o,
    output logic [3:0]    wb_sel_o,
    output logic [31:0]   wb_dat_o,
    output logic          wb_stb_o,
    output logic          wb_cyc_o,
    output logic          wb_wre_o,
    output logic          wb_tag_o,
    input  logic [31:0]   wb_dat_i,
    input  logic          wb_ack_i,
    output logic [1:0]    gnt_o,
    output logic          tmo_o
);

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   req_d, req_i;
    logic   owner_cyc;
    logic   wdt_fire;

    assign req_d = d_cyc_i & d_stb_i;
    assign req_i = i_cyc_i & i_stb_i;

    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_I;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // The owner keeps the bus for as long as its cyc is high (bus lock).
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_GNT_D: if (!d_cyc_i) state_d = arbitrate(req_d, req_i, last_q);
            ST_GNT_I: if (!i_cyc_i) state_d = arbitrate(req_d, req_i, last_q);
            default:  state_d = arbitrate(req_d, req_i, last_q);
        endcase
        if (state_d == ST_GNT_D)
            last_d = LAST_D;
        else if (state_d == ST_GNT_I)
            last_d = LAST_I;
    end

    always_comb begin
        wb_adr_o  = '0;
        wb_sel_o  = 4'h0;
        wb_dat_o  = 32'h0;
        wb_stb_o  = 1'b0;
        wb_cyc_o  = 1'b0;
        wb_wre_o  = 1'b0;
        wb_tag_o  = 1'b0;
        gnt_o     = 2'b00;
        owner_cyc = 1'b0;
        case (state_q)
            ST_GNT_D: begin
                wb_adr_o  = d_adr_i;
                wb_sel_o  = d_sel_i;
                wb_dat_o  = d_dat_i;
                wb_stb_o  = d_stb_i;
                wb_cyc_o  = d_cyc_i;
                wb_wre_o  = d_wre_i;
                wb_tag_o  = d_tag_i;
                gnt_o     = GNT_D;
                owner_cyc = d_cyc_i;
            end
            ST_GNT_I: begin
                wb_adr_o  = i_adr_i;
                wb_sel_o  = 4'hF;
                wb_stb_o  = i_stb_i;
                wb_cyc_o  = i_cyc_i;
                wb_tag_o  = i_tag_i;
                gnt_o     = GNT_I;
                owner_cyc = i_cyc_i;
            end
            default: ;
        endcase
        // Release cycle: keep the slave from seeing a stray strobe.
        if (!owner_cyc) begin
            wb_stb_o = 1'b0;
            wb_cyc_o = 1'b0;
        end
    end

`ifdef AEMB_WBARB_WDT_EN
    aemb_wbarb_wdt #(
        .TMO(TMO)
    ) u_wdt (
        .gclk   (gclk),
        .grst   (grst),
        .stall_i(wb_stb_o & ~wb_ack_i),
        .clr_i  (wb_ack_i | (state_d != state_q)),
        .fire_o (wdt_fire),
        .tmo_o  (tmo_o)
    );
`else
    logic unused_tmo;
    assign unused_tmo = ^8'(TMO);
    assign wdt_fire   = 1'b0;
    assign tmo_o      = 1'b0;
`endif

    assign d_ack_o = (wb_ack_i | wdt_fire) & (state_q == ST_GNT_D);
    assign i_ack_o = (wb_ack_i | wdt_fire) & (state_q == ST_GNT_I);
    assign d_dat_o = (wdt_fire && state_q == ST_GNT_D) ? 32'h0 : wb_dat_i;
    assign i_dat_o = (wdt_fire && state_q == ST_GNT_I) ? 32'h0 : wb_dat_i;

endmodule
